// File: rtl/pointer_motion.sv
// pointer_motion: per-frame accelerating pointer position controller.
// Buttons are sampled on the rising edge of vblnk_in, and the outputs update on the next clk edge.
module pointer_motion #(
  parameter int X_INIT    = 400,
  parameter int Y_INIT    = 300,
  parameter int X_MAX     = 789,
  parameter int Y_MAX     = 586,
  parameter int MAX_SPEED = 8,
  parameter int ACCEL_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] x_pointer,
  output logic [10:0] y_pointer,
  output logic [3:0]  speed,
  output logic        moving
);
  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [3:0]  speed_q, speed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vblnk_q;
  logic        tick, active, x_inc, x_dec, y_inc, y_dec;
  assign tick   = vblnk_in & ~vblnk_q;
  assign x_inc  = btn_right & ~btn_left;
  assign x_dec  = btn_left & ~btn_right;
  assign y_inc  = btn_down & ~btn_up;
  assign y_dec  = btn_up & ~btn_down;
  assign active = x_inc | x_dec | y_inc | y_dec;
  // p <= lim and step <= 15, so bit 11 of the 12-bit sum is the sign of the result.
  function automatic logic [10:0] step_clamp(input logic [10:0] p, input logic inc, input logic dec,
                                             input logic [3:0] s, input logic [10:0] lim);
    logic [11:0] n;
    n = inc ? {1'b0, p} + {8'd0, s} : dec ? {1'b0, p} - {8'd0, s} : {1'b0, p};
    return n[11] ? 11'd0 : (n > {1'b0, lim}) ? lim : n[10:0];
  endfunction
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = active ? ACCEL : IDLE;
          speed_d = active ? 4'd1 : 4'd0;
          cnt_d   = 8'd0;
        end
        ACCEL: begin
          if (!active) begin
            state_d = IDLE;
            speed_d = 4'd0;
          end else if (cnt_q == 8'(ACCEL_DIV - 1)) begin
            cnt_d   = 8'd0;
            speed_d = speed_q + 4'd1;
            state_d = (speed_q + 4'd1 == 4'(MAX_SPEED)) ? CRUISE : ACCEL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        CRUISE: begin
          state_d = active ? CRUISE : IDLE;
          speed_d = active ? 4'(MAX_SPEED) : 4'd0;
        end
        default: begin
          state_d = IDLE;
          speed_d = 4'd0;
        end
      endcase
    end
    x_d = tick ? step_clamp(x_q, x_inc, x_dec, speed_d, 11'(X_MAX)) : x_q;
    y_d = tick ? step_clamp(y_q, y_inc, y_dec, speed_d, 11'(Y_MAX)) : y_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      speed_q <= 4'd0;
      cnt_q   <= 8'd0;
      x_q     <= 11'(X_INIT);
      y_q     <= 11'(Y_INIT);
      vblnk_q <= 1'b1;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vblnk_q <= vblnk_in;
    end
  end
  assign x_pointer = x_q;
  assign y_pointer = y_q;
  assign speed     = speed_q;
  assign moving    = state_q != IDLE;
endmodule

// File: tb/tb_pointer_motion.sv
// tb_pointer_motion: directed frame-by-frame checks of pointer_motion against a tick model.
module tb_pointer_motion;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vblnk_in = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [10:0] x_pointer, y_pointer;
  logic [3:0]  speed;
  logic        moving;
  int n_chk = 0;
  int n_fail = 0;
  int mx = 400, my = 300, ms = 0, run = 0;
  int xs[5] = '{401, 402, 403, 404, 406};
  int ss[5] = '{1, 1, 1, 1, 2};

  pointer_motion dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x_pointer(x_pointer), .y_pointer(y_pointer), .speed(speed), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_x"}, 32'(x_pointer), 32'(mx));
    chk({tag, "_y"}, 32'(y_pointer), 32'(my));
    chk({tag, "_speed"}, 32'(speed), 32'(ms));
    chk({tag, "_moving"}, 32'(moving), 32'(ms != 0));
  endtask

  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : v > hi ? hi : v;
  endfunction

  // Speed follows the count of consecutive active frames: 1 for the first four, +1 every four after, capped at 8.
  task automatic model(input logic u, input logic d, input logic l, input logic r);
    int dx, dy;
    dx = (r && !l) ? 1 : (l && !r) ? -1 : 0;
    dy = (d && !u) ? 1 : (u && !d) ? -1 : 0;
    run = (dx != 0 || dy != 0) ? run + 1 : 0;
    ms = run == 0 ? 0 : (1 + (run - 1) / 4 > 8 ? 8 : 1 + (run - 1) / 4);
    mx = clampi(mx + dx * ms, 789);
    my = clampi(my + dy * ms, 586);
  endtask

  task automatic frame(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk);
    vblnk_in = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
    repeat (2) @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = {u, d, l, r};
    vblnk_in = 1'b1;
    #1 chk("pre_tick_x", 32'(x_pointer), 32'(mx));
    @(negedge clk);
    model(u, d, l, r);
    chk_all("tick");
    {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
    @(negedge clk);
    chk("hold_x", 32'(x_pointer), 32'(mx));
    chk("hold_speed", 32'(speed), 32'(ms));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_hold_x", 32'(x_pointer), 32'd400);
    end
    chk_all("reset");
    vblnk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("vblnk_fall");

    for (int i = 0; i < 5; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b1);
      chk("right5_x", 32'(x_pointer), 32'(xs[i]));
      chk("right5_speed", 32'(speed), 32'(ss[i]));
    end
    for (int i = 0; i < 65; i++) frame(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clamp_right_x", 32'(x_pointer), 32'd789);
    chk("cruise_speed", 32'(speed), 32'd8);
    chk("cruise_moving", 32'(moving), 32'd1);

    @(negedge clk);
    vblnk_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_right = 1'b1;
    vblnk_in = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mx = 400; my = 300; ms = 0; run = 0;
    chk_all("rst_on_tick");
    @(negedge clk);
    chk_all("rst_no_tick");
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_rst_x", 32'(x_pointer), 32'd401);
    chk("after_rst_speed", 32'(speed), 32'd1);

    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_speed", 32'(speed), 32'd0);
    for (int i = 0; i < 68; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clamp_left_x", 32'(x_pointer), 32'd0);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clamp_left_hold", 32'(x_pointer), 32'd0);

    frame(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 1'b1, 1'b1);
    chk("lr_cancel_speed", 32'(speed), 32'd0);
    frame(1'b1, 1'b0, 1'b1, 1'b1);
    chk("lr_up_y", 32'(y_pointer), 32'd299);
    chk("lr_up_x", 32'(x_pointer), 32'd0);
    frame(1'b1, 1'b0, 1'b1, 1'b1);
    chk("lr_up_y2", 32'(y_pointer), 32'd298);
    frame(1'b0, 1'b1, 1'b0, 1'b1);
    chk("turn_keeps_speed", 32'(speed), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
